// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control FSM.
// State register plus Moore output decode; strobes gated by reset.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       OV,
    output logic       PCWr,
    output logic       IRWr,
    output logic       MemWr,
    output logic       RFWr,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       RegDst,
    output logic       WDSel,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_MA    = 4'd2,
        S_MR    = 4'd3,
        S_MWB   = 4'd4,
        S_MW    = 4'd5,
        S_EXE   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_IEXE  = 4'd10,
        S_IWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_t cur;
    logic   ov_flag;
    logic   rtype_ok;
    logic   pc_wr_raw;
    logic   ir_wr_raw;
    logic   mem_wr_raw;
    logic   rf_wr_raw;

    assign state = cur;

    always_comb begin
        rtype_ok = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                6'b100001, 6'b100011, 6'b100101,
                6'b100100, 6'b101010: rtype_ok = 1'b1;
                default:              rtype_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= S_FETCH;
            ov_flag <= 1'b0;
        end else begin
            case (cur)
                S_FETCH: cur <= S_DCD;
                S_DCD: begin
                    if (opcode == OP_LW || opcode == OP_SW)
                        cur <= S_MA;
                    else if (rtype_ok)
                        cur <= S_EXE;
                    else if (opcode == OP_BEQ)
                        cur <= S_BR;
                    else if (opcode == OP_J)
                        cur <= S_JMP;
                    else if (opcode == OP_ADDI || opcode == OP_ORI)
                        cur <= S_IEXE;
                    else
                        cur <= S_FETCH;
                end
                S_MA:  cur <= (opcode == OP_LW) ? S_MR : S_MW;
                S_MR:  cur <= S_MWB;
                S_EXE: cur <= S_RWB;
                S_IEXE: begin
                    cur     <= S_IWB;
                    ov_flag <= (opcode == OP_ADDI) & OV;
                end
                default: cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_wr_raw  = 1'b0;
        ir_wr_raw  = 1'b0;
        mem_wr_raw = 1'b0;
        rf_wr_raw  = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ExtOp      = 1'b0;
        ALUOp      = 3'b000;
        PCSrc      = 2'b00;
        RegDst     = 1'b0;
        WDSel      = 1'b0;
        case (cur)
            S_FETCH: begin
                ir_wr_raw = 1'b1;
                pc_wr_raw = 1'b1;
                ALUSrcB   = 2'b01;
            end
            S_DCD: begin
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
            end
            S_MA: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
            end
            S_MR: IorD = 1'b1;
            S_MWB: begin
                rf_wr_raw = 1'b1;
                WDSel     = 1'b1;
            end
            S_MW: begin
                IorD       = 1'b1;
                mem_wr_raw = 1'b1;
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                case (funct)
                    6'b100011: ALUOp = 3'b001;
                    6'b100101: ALUOp = 3'b010;
                    6'b100100: ALUOp = 3'b011;
                    6'b101010: ALUOp = 3'b100;
                    default:   ALUOp = 3'b000;
                endcase
            end
            S_RWB: begin
                rf_wr_raw = 1'b1;
                RegDst    = 1'b1;
            end
            S_BR: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 3'b001;
                PCSrc     = 2'b01;
                pc_wr_raw = zero;
            end
            S_JMP: begin
                PCSrc     = 2'b10;
                pc_wr_raw = 1'b1;
            end
            S_IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_ORI) begin
                    ALUOp = 3'b010;
                end else begin
                    ExtOp = 1'b1;
                end
            end
            S_IWB: rf_wr_raw = ~ov_flag;
            default: ;
        endcase
    end

    assign PCWr  = pc_wr_raw  & ~rst;
    assign IRWr  = ir_wr_raw  & ~rst;
    assign MemWr = mem_wr_raw & ~rst;
    assign RFWr  = rf_wr_raw  & ~rst;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none; all encodings fixed by this document.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 opcode  in  6  IR[31:26].
REQ-005 funct  in  6  IR[5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 OV  in  1  ALU overflow flag (valid for addi only).
REQ-008 PCWr  out  1  PC write strobe.
REQ-009 IRWr  out  1  IR write strobe.
REQ-010 MemWr  out  1  data memory write strobe.
REQ-011 RFWr  out  1  register file write strobe.
REQ-012 IorD  out  1  memory address: 0=PC, 1=ALUOut reg.
REQ-013 ALUSrcA  out  1  ALU A: 0=PC, 1=reg A.
REQ-014 ALUSrcB  out  2  ALU B: 00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2.
REQ-015 ExtOp  out  1  imm extend: 1=sign, 0=zero.
REQ-016 ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 slt.
REQ-017 PCSrc  out  2  PC source: 00=ALU result, 01=ALUOut reg, 10=jump target.
REQ-018 RegDst  out  1  write register: 0=rt, 1=rd.
REQ-019 WDSel  out  1  RF write data: 0=ALUOut reg, 1=MDR.
REQ-020 state  out  4  current state, for debug/bench.

Function
REQ-021 States: FETCH=0, DCD=1, MA=2, MR=3, MWB=4, MW=5, EXE=6, RWB=7, BR=8, JMP=9, IEXE=10, IWB=11; codes 12-15 unreachable, go to FETCH next cycle with all strobes 0.
REQ-022 Outputs Moore-decoded from state (plus funct in EXE, latched OV in IWB); any output not listed for a state is 0.
REQ-023 FETCH: IorD=0, IRWr=1, PCWr=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00; next DCD.
REQ-024 DCD: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=000 (branch target into ALUOut); next by opcode: 100011/101011->MA, 000000 with funct in {100001,100011,100101,100100,101010}->EXE, 000100->BR, 000010->JMP, 001000/001101->IEXE, anything else->FETCH (NOP).
REQ-025 MA: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=000; next MR if lw, MW if sw.
REQ-026 MR: IorD=1; next MWB. MWB: RFWr=1, WDSel=1, RegDst=0; next FETCH. MW: IorD=1, MemWr=1; next FETCH.
REQ-027 EXE: ALUSrcA=1, ALUSrcB=00, ALUOp per funct 100001->000, 100011->001, 100101->010, 100100->011, 101010->100; next RWB. RWB: RFWr=1, WDSel=0, RegDst=1; next FETCH.
REQ-028 BR: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01, PCWr=zero (sampled same cycle); next FETCH.
REQ-029 JMP: PCSrc=10, PCWr=1; next FETCH.
REQ-030 IEXE: ALUSrcA=1, ALUSrcB=10, ExtOp=1 and ALUOp=000 for addi, ExtOp=0 and ALUOp=010 for ori; ov_flag register <= OV at end of IEXE if addi, else 0; next IWB.
REQ-031 IWB: WDSel=0, RegDst=0, RFWr = ~ov_flag; next FETCH.
REQ-032 Latency in cycles: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3, undefined 2.

Reset
REQ-033 rst high: state=FETCH and ov_flag=0 immediately (asynchronous); PCWr, IRWr, MemWr, RFWr forced 0 while rst high, regardless of state.
REQ-034 rst mid-instruction aborts it: no further strobe for that instruction; first FETCH strobes on the first rising edge after rst falls.

Verification
REQ-035 rst high 3 cycles, release -> state=0 with strobes 0 during rst; first cycle after release PCWr=1, IRWr=1, ALUSrcB=01.
REQ-036 opcode=100011 -> state 0,1,2,3,4,0; RFWr=1 only in state 4 with WDSel=1, RegDst=0; MemWr never 1.
REQ-037 opcode=000100, zero=1 then zero=0 on two runs -> state 8 PCSrc=01 with PCWr=1 resp. 0; return to state 0.
REQ-038 opcode=001000, OV=1 in state 10 -> state 11 RFWr=0; repeat with OV=0 -> RFWr=1; opcode=001101 -> ExtOp=0, ALUOp=010.
REQ-039 opcode=000000 funct=101010 -> state 6 ALUOp=100, ALUSrcA=1, ALUSrcB=00; state 7 RFWr=1, RegDst=1; funct=000000 -> DCD->FETCH, no RFWr.
REQ-040 lw, rst asserted asynchronously in state 3 -> state=0 immediately, RFWr never asserted for that lw.
